// File: rtl/imem_loader.sv
// Loads a framed serial byte stream into instruction memory as big-endian 32-bit words, holding the CPU meanwhile.
// Latency: imem_we pulses one cycle after the 4th byte of a word; load_done/error rise one cycle after the checksum byte.
// Backpressure: none; one byte per cycle is accepted at full rate and the rx stream is never stalled.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 1000000
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              program_en,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              error,
    output logic [15:0]       word_count
);

    localparam int IDLE_W = $clog2(TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
    localparam logic [15:0]       MAX_LEN    = 16'(MAX_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       len_q;
    logic [15:0]       len_full;
    logic [7:0]        csum;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic [ADDR_W-1:0] addr_cnt;
    logic [IDLE_W-1:0] idle_cnt;

    logic in_frame;
    logic timed;
    logic abort;
    logic byte_acc;
    logic timeout_hit;
    logic start;
    logic write_issue;

    assign in_frame    = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                         (state == S_DATA)   || (state == S_CHECK);
    assign timed       = (state == S_LEN_LO) || (state == S_DATA) || (state == S_CHECK);
    assign abort       = in_frame && !program_en;
    assign byte_acc    = in_frame && program_en && rx_valid;
    // An accepted byte in the same cycle beats the timeout.
    assign timeout_hit = timed && program_en && !rx_valid && (idle_cnt == IDLE_LIMIT);
    assign len_full    = {len_q[15:8], rx_byte};
    assign imem_addr   = addr_cnt;

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        start       = 1'b0;
        write_issue = 1'b0;
        cpu_hold    = 1'b0;
        load_done   = 1'b0;
        error       = 1'b0;

        case (state)
            S_IDLE: begin
                if (program_en) begin
                    state_nxt = S_LEN_HI;
                    start     = 1'b1;
                end
            end
            S_LEN_HI: begin
                cpu_hold = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (byte_acc) begin
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                cpu_hold = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (byte_acc) begin
                    if (len_full > MAX_LEN) begin
                        state_nxt = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_nxt = S_CHECK;
                    end else begin
                        state_nxt = S_DATA;
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_DATA: begin
                cpu_hold = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (byte_acc) begin
                    if (byte_cnt == 2'd3) begin
                        write_issue = 1'b1;
                        if (word_count + 16'd1 == len_q) begin
                            state_nxt = S_CHECK;
                        end
                    end
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_CHECK: begin
                cpu_hold = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (byte_acc) begin
                    state_nxt = (rx_byte == csum) ? S_DONE : S_ERR;
                end else if (timeout_hit) begin
                    state_nxt = S_ERR;
                end
            end
            S_DONE: begin
                load_done = 1'b1;
                if (!program_en) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                cpu_hold = 1'b1;
                error    = 1'b1;
                if (!program_en) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            imem_we    <= 1'b0;
            imem_wdata <= 32'd0;
            word_count <= 16'd0;
            addr_cnt   <= '0;
            len_q      <= 16'd0;
            csum       <= 8'd0;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            idle_cnt   <= '0;
        end else begin
            imem_we <= write_issue;

            if (start) begin
                word_count <= 16'd0;
                addr_cnt   <= '0;
                len_q      <= 16'd0;
                csum       <= 8'd0;
                byte_cnt   <= 2'd0;
            end else begin
                // Address advances once the write pulse has been presented.
                if (imem_we) begin
                    addr_cnt <= addr_cnt + ADDR_ONE;
                end
                if (byte_acc) begin
                    if (state != S_CHECK) begin
                        csum <= csum ^ rx_byte;
                    end
                    if (state == S_LEN_HI) begin
                        len_q[15:8] <= rx_byte;
                    end
                    if (state == S_LEN_LO) begin
                        len_q[7:0] <= rx_byte;
                    end
                    if (state == S_DATA) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        shift    <= {shift[15:0], rx_byte};
                    end
                end
                if (write_issue) begin
                    imem_wdata <= {shift, rx_byte};
                    word_count <= word_count + 16'd1;
                end
            end

            if (byte_acc || !timed) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + IDLE_ONE;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scripted frames per scenario, expected writes tracked in a scoreboard queue.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        program_en;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        error;
    logic [15:0] word_count;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] frame_q[$];
    int         tests_run   = 0;
    int         failures    = 0;
    int         write_count = 0;

    localparam logic [7:0] NORMAL [0:9] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00,
                                            8'h05, 8'hAC, 8'h08, 8'h00, 8'h04};

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256), .TIMEOUT(16)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .program_en (program_en),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Scoreboard: each write pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_t e;
            write_count++;
            tests_run++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%0h data=%h, expected no write", imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                if (imem_addr !== e.addr || imem_wdata !== e.data) begin
                    failures++;
                    $display("FAIL write: got addr=%0h data=%h, expected addr=%0h data=%h",
                             imem_addr, imem_wdata, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame();
        while (frame_q.size() > 0) begin
            rx_valid = 1'b1;
            rx_byte  = frame_q.pop_front();
            tick();
        end
        rx_valid = 1'b0;
    endtask

    task automatic push_normal(input logic [7:0] csum_byte);
        foreach (NORMAL[i]) frame_q.push_back(NORMAL[i]);
        frame_q.push_back(csum_byte);
    endtask

    task automatic push_normal_writes();
        exp_q.push_back('{addr: 8'd0, data: 32'h20080005});
        exp_q.push_back('{addr: 8'd1, data: 32'hAC080004});
    endtask

    task automatic leave_frame();
        program_en = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_reset = 1'b0; program_en = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        tick(); tick();
        tests_run++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, error, word_count} !== 60'd0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h hold=%b done=%b err=%b cnt=%h, expected all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, load_done, error, word_count);
        end
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_normal_load();
        program_en = 1'b1;
        tick();
        tests_run++;
        if (cpu_hold !== 1'b1) begin
            failures++; $display("FAIL hold_rise: got %b expected 1", cpu_hold);
        end
        push_normal(8'h8F);
        push_normal_writes();
        send_frame();
        tests_run++;
        if (load_done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++; $display("FAIL normal_flags: got done=%b err=%b hold=%b expected 1 0 0", load_done, error, cpu_hold);
        end
        tests_run++;
        if (word_count !== 16'd2) begin
            failures++; $display("FAIL normal_count: got %0d expected 2", word_count);
        end
        tests_run++;
        if (exp_q.size() != 0) begin
            failures++; $display("FAIL normal_drain: got %0d pending writes expected 0", exp_q.size());
        end
        leave_frame();
        tests_run++;
        if (load_done !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++; $display("FAIL normal_idle: got done=%b hold=%b expected 0 0", load_done, cpu_hold);
        end
    endtask

    task automatic test_bad_checksum();
        program_en = 1'b1;
        tick();
        push_normal(8'h8E);
        push_normal_writes();
        send_frame();
        tests_run++;
        if (error !== 1'b1 || cpu_hold !== 1'b1 || load_done !== 1'b0) begin
            failures++; $display("FAIL badsum_flags: got err=%b hold=%b done=%b expected 1 1 0", error, cpu_hold, load_done);
        end
        tests_run++;
        if (exp_q.size() != 0 || word_count !== 16'd2) begin
            failures++; $display("FAIL badsum_writes: got pending=%0d cnt=%0d expected 0 2", exp_q.size(), word_count);
        end
        leave_frame();
        tests_run++;
        if (error !== 1'b0 || load_done !== 1'b0 || cpu_hold !== 1'b0) begin
            failures++; $display("FAIL badsum_idle: got err=%b done=%b hold=%b expected 0 0 0", error, load_done, cpu_hold);
        end
    endtask

    task automatic test_oversize();
        int wc0;
        wc0 = write_count;
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h01);
        send_frame();
        tests_run++;
        if (error !== 1'b0) begin
            failures++; $display("FAIL oversize_early: got err=%b expected 0", error);
        end
        frame_q.push_back(8'h01);
        send_frame();
        tests_run++;
        if (error !== 1'b1) begin
            failures++; $display("FAIL oversize_err: got err=%b expected 1", error);
        end
        tick(); tick();
        tests_run++;
        if (write_count != wc0) begin
            failures++; $display("FAIL oversize_nowrite: got %0d writes expected 0", write_count - wc0);
        end
        leave_frame();
    endtask

    task automatic test_empty();
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h00);
        send_frame();
        tests_run++;
        if (load_done !== 1'b1 || word_count !== 16'd0) begin
            failures++; $display("FAIL empty_ok: got done=%b cnt=%0d expected 1 0", load_done, word_count);
        end
        leave_frame();
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h00); frame_q.push_back(8'h00); frame_q.push_back(8'h01);
        send_frame();
        tests_run++;
        if (error !== 1'b1 || load_done !== 1'b0) begin
            failures++; $display("FAIL empty_badsum: got err=%b done=%b expected 1 0", error, load_done);
        end
        leave_frame();
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h00); frame_q.push_back(8'h02); frame_q.push_back(8'h20);
        frame_q.push_back(8'h08); frame_q.push_back(8'h00);
        send_frame();
        for (int k = 1; k <= 15; k++) begin
            tick();
            if (error !== 1'b0) early = 1'b1;
        end
        tests_run++;
        if (early !== 1'b0) begin
            failures++; $display("FAIL timeout_early: got error before 16 cycles, expected none");
        end
        tick();
        tests_run++;
        if (error !== 1'b1 || cpu_hold !== 1'b1) begin
            failures++; $display("FAIL timeout_err: got err=%b hold=%b expected 1 1", error, cpu_hold);
        end
        leave_frame();
    endtask

    task automatic test_abort();
        int wc0;
        wc0 = write_count;
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h00); frame_q.push_back(8'h01);
        frame_q.push_back(8'hAA); frame_q.push_back(8'hBB);
        send_frame();
        program_en = 1'b0; rx_valid = 1'b1; rx_byte = 8'hCC;
        tick();
        rx_valid = 1'b0;
        tests_run++;
        if (cpu_hold !== 1'b0 || load_done !== 1'b0 || error !== 1'b0) begin
            failures++; $display("FAIL abort_idle: got hold=%b done=%b err=%b expected 0 0 0", cpu_hold, load_done, error);
        end
        tick();
        tests_run++;
        if (write_count != wc0) begin
            failures++; $display("FAIL abort_nowrite: got %0d writes expected 0", write_count - wc0);
        end
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h00); frame_q.push_back(8'h01); frame_q.push_back(8'h11);
        frame_q.push_back(8'h22); frame_q.push_back(8'h33); frame_q.push_back(8'h44);
        frame_q.push_back(8'h45);
        exp_q.push_back('{addr: 8'd0, data: 32'h11223344});
        send_frame();
        tests_run++;
        if (load_done !== 1'b1 || word_count !== 16'd1 || exp_q.size() != 0) begin
            failures++; $display("FAIL abort_reload: got done=%b cnt=%0d pending=%0d expected 1 1 0",
                                 load_done, word_count, exp_q.size());
        end
        leave_frame();
    endtask

    task automatic test_reset_mid_frame();
        program_en = 1'b1;
        tick();
        frame_q.push_back(8'h00); frame_q.push_back(8'h02); frame_q.push_back(8'hDE);
        frame_q.push_back(8'hAD); frame_q.push_back(8'hBE); frame_q.push_back(8'hEF);
        frame_q.push_back(8'h01);
        exp_q.push_back('{addr: 8'd0, data: 32'hDEADBEEF});
        send_frame();
        n_reset = 1'b0;
        tick();
        tests_run++;
        if ({imem_we, imem_addr, imem_wdata, cpu_hold, load_done, error, word_count} !== 60'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got we=%b addr=%h data=%h hold=%b done=%b err=%b cnt=%h, expected all 0",
                     imem_we, imem_addr, imem_wdata, cpu_hold, load_done, error, word_count);
        end
        n_reset = 1'b1;
        tick();
        push_normal(8'h8F);
        push_normal_writes();
        send_frame();
        tests_run++;
        if (load_done !== 1'b1 || word_count !== 16'd2 || exp_q.size() != 0) begin
            failures++; $display("FAIL midreset_reload: got done=%b cnt=%0d pending=%0d expected 1 2 0",
                                 load_done, word_count, exp_q.size());
        end
        leave_frame();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [7:0]  cs;
        program_en = 1'b1;
        tick();
        cs = 8'h04;
        frame_q.push_back(8'h00); frame_q.push_back(8'h04);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            exp_q.push_back('{addr: 8'(i), data: w});
            for (int b = 3; b >= 0; b--) begin
                frame_q.push_back(w[b*8 +: 8]);
                cs = cs ^ w[b*8 +: 8];
            end
        end
        frame_q.push_back(cs);
        send_frame();
        tests_run++;
        if (load_done !== 1'b1 || word_count !== 16'd4 || exp_q.size() != 0) begin
            failures++; $display("FAIL b2b_load: got done=%b cnt=%0d pending=%0d expected 1 4 0",
                                 load_done, word_count, exp_q.size());
        end
        leave_frame();
    endtask

    initial begin
        test_reset();
        test_normal_load();
        test_bad_checksum();
        test_oversize();
        test_empty();
        test_timeout();
        test_abort();
        test_reset_mid_frame();
        test_back_to_back();
        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
